alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Button-stepped operand/opcode loader for a combinational ALU.
// Loads A, B, opcode+flag, waits one settle cycle, then captures the result.
module alu_op_sequencer #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             btn_next,
  input  logic             flag_in_sw,
  output logic [WIDTH-1:0] ALUA,
  output logic [WIDTH-1:0] ALUB,
  output logic [3:0]       ALUControl,
  output logic             ALUFlagIn,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             ALUFlags,
  output logic [WIDTH-1:0] result_q,
  output logic             flags_q,
  output logic             valid,
  output logic             op_err,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_v1;
  logic r_v2;
  logic r_armed;
  logic w_adv;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_ctrl;
  logic             r_fin;
  logic [WIDTH-1:0] r_res;
  logic             r_flg;
  logic             r_valid;
  logic             r_op_err;

  logic w_op_legal;
  logic w_ld_a;
  logic w_ld_b;
  logic w_ld_op;
  logic w_op_bad;
  logic w_cap;
  logic w_clr;

  // r_v1/r_v2 mark sync stages holding real samples; arming needs a real low
  // so a button held through reset release never produces an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= btn_next;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_v1    <= 1'b1;
      r_v2    <= r_v1;
      r_armed <= r_armed | (r_v2 & ~r_sync2);
    end
  end

  assign w_adv = r_sync2 & ~r_sync3 & r_armed;

  assign w_op_legal =
    ({{(32-WIDTH){1'b0}}, data_in} < 32'(NUM_OPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD_A;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = LOAD_A;
    unique case (r_state)
      LOAD_A:  w_next = w_adv ? LOAD_B : LOAD_A;
      LOAD_B:  w_next = w_adv ? LOAD_OP : LOAD_B;
      LOAD_OP: w_next = (w_adv && w_op_legal) ? EXEC : LOAD_OP;
      EXEC:    w_next = SHOW;
      SHOW:    w_next = w_adv ? LOAD_A : SHOW;
      default: w_next = LOAD_A;
    endcase
  end

  always_comb begin
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_ld_op  = 1'b0;
    w_op_bad = 1'b0;
    w_cap    = 1'b0;
    w_clr    = 1'b0;
    unique case (1'b1)
      (r_state == LOAD_A):  w_ld_a = w_adv;
      (r_state == LOAD_B):  w_ld_b = w_adv;
      (r_state == LOAD_OP): begin
        w_ld_op  = w_adv & w_op_legal;
        w_op_bad = w_adv & ~w_op_legal;
      end
      (r_state == EXEC):    w_cap = 1'b1;
      (r_state == SHOW):    w_clr = w_adv;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_ctrl   <= '0;
      r_fin    <= 1'b0;
      r_res    <= '0;
      r_flg    <= 1'b0;
      r_valid  <= 1'b0;
      r_op_err <= 1'b0;
    end else begin
      r_op_err <= w_op_bad;
      if (w_ld_a) r_a <= data_in;
      if (w_ld_b) r_b <= data_in;
      if (w_ld_op) begin
        r_ctrl <= 4'(data_in);
        r_fin  <= flag_in_sw;
      end
      if (w_cap) begin
        r_res   <= ALUResult;
        r_flg   <= ALUFlags;
        r_valid <= 1'b1;
      end else if (w_clr) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ALUA       = r_a;
  assign ALUB       = r_b;
  assign ALUControl = r_ctrl;
  assign ALUFlagIn  = r_fin;
  assign result_q   = r_res;
  assign flags_q    = r_flg;
  assign valid      = r_valid;
  assign op_err     = r_op_err;
  assign state      = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer.
// ALU outputs are driven as a stub with fixed values per scenario.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in = '0;
  logic       btn_next = 1'b0;
  logic       flag_in_sw = 1'b0;
  logic [3:0] ALUA, ALUB, ALUControl;
  logic       ALUFlagIn;
  logic [3:0] ALUResult = '0;
  logic       ALUFlags = 1'b0;
  logic [3:0] result_q;
  logic       flags_q, valid, op_err;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  alu_op_sequencer #(.WIDTH(4), .NUM_OPS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .btn_next(btn_next),
    .flag_in_sw(flag_in_sw),
    .ALUA(ALUA), .ALUB(ALUB),
    .ALUControl(ALUControl), .ALUFlagIn(ALUFlagIn),
    .ALUResult(ALUResult), .ALUFlags(ALUFlags),
    .result_q(result_q), .flags_q(flags_q),
    .valid(valid), .op_err(op_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic press();
    btn_next = 1'b1;
    repeat (6) @(negedge clk);
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({state, ALUA, ALUB, ALUControl, ALUFlagIn,
         result_q, flags_q, valid, op_err} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_outputs state=%0d A=%h B=%h ctl=%h v=%b err=%b want all 0",
               state, ALUA, ALUB, ALUControl, valid, op_err);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_idle state=%0d want 0", state);
    end
  endtask

  task automatic test_load_seq();
    data_in = 4'b1011;
    press();
    n_vec++;
    if (state !== 3'd1 || ALUA !== 4'hB) begin
      n_err++;
      $display("FAIL load_a state=%0d A=%h want 1/B", state, ALUA);
    end
    data_in = 4'b0111;
    press();
    n_vec++;
    if (state !== 3'd2 || ALUB !== 4'h7) begin
      n_err++;
      $display("FAIL load_b state=%0d B=%h want 2/7", state, ALUB);
    end
    data_in = 4'h0;
    flag_in_sw = 1'b0;
    ALUResult = 4'h2;
    ALUFlags = 1'b1;
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (state !== 3'd3 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL exec_cycle state=%0d valid=%b want 3/0", state, valid);
    end
    @(negedge clk);
    n_vec++;
    if (state !== 3'd4 || valid !== 1'b1 || result_q !== 4'h2 ||
        flags_q !== 1'b1 || ALUControl !== 4'h0) begin
      n_err++;
      $display("FAIL show_capture state=%0d v=%b res=%h f=%b ctl=%h want 4/1/2/1/0",
               state, valid, result_q, flags_q, ALUControl);
    end
    ALUResult = 4'hF;
    ALUFlags = 1'b0;
    data_in = 4'h3;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++;
    if (state !== 3'd4 || result_q !== 4'h2 || flags_q !== 1'b1 ||
        ALUA !== 4'hB || ALUB !== 4'h7 || valid !== 1'b1) begin
      n_err++;
      $display("FAIL show_stable state=%0d res=%h f=%b A=%h B=%h want 4/2/1/B/7",
               state, result_q, flags_q, ALUA, ALUB);
    end
  endtask

  task automatic test_return();
    data_in = 4'h4;
    press();
    n_vec++;
    if (state !== 3'd0 || valid !== 1'b0 || ALUA !== 4'hB) begin
      n_err++;
      $display("FAIL return state=%0d v=%b A=%h want 0/0/B", state, valid, ALUA);
    end
  endtask

  task automatic test_held();
    data_in = 4'h3;
    btn_next = 1'b1;
    repeat (50) @(negedge clk);
    n_vec++;
    if (state !== 3'd1 || ALUA !== 4'h3) begin
      n_err++;
      $display("FAIL held_button state=%0d A=%h want 1/3", state, ALUA);
    end
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_illegal();
    int pulses;
    data_in = 4'h5;
    press();
    data_in = 4'hC;
    flag_in_sw = 1'b1;
    pulses = 0;
    btn_next = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (op_err === 1'b1) pulses++;
      if (i == 5) btn_next = 1'b0;
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL op_err_pulse cycles=%0d want 1", pulses);
    end
    n_vec++;
    if (state !== 3'd2 || ALUControl !== 4'h0 || ALUFlagIn !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_hold state=%0d ctl=%h fin=%b want 2/0/0",
               state, ALUControl, ALUFlagIn);
    end
    data_in = 4'h9;
    ALUResult = 4'h5;
    ALUFlags = 1'b0;
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (state !== 3'd3 || ALUControl !== 4'h9 || ALUFlagIn !== 1'b1) begin
      n_err++;
      $display("FAIL legal_op state=%0d ctl=%h fin=%b want 3/9/1",
               state, ALUControl, ALUFlagIn);
    end
    @(negedge clk);
    n_vec++;
    if (state !== 3'd4 || result_q !== 4'h5 || flags_q !== 1'b0 ||
        ALUA !== 4'h3 || ALUB !== 4'h5) begin
      n_err++;
      $display("FAIL second_result state=%0d res=%h f=%b A=%h B=%h want 4/5/0/3/5",
               state, result_q, flags_q, ALUA, ALUB);
    end
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    press();
    data_in = 4'hA;
    press();
    data_in = 4'h6;
    press();
    n_vec++;
    if (state !== 3'd2) begin
      n_err++;
      $display("FAIL reach_load_op state=%0d want 2", state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({state, ALUA, ALUB, ALUControl, ALUFlagIn,
         result_q, flags_q, valid, op_err} !== 23'd0) begin
      n_err++;
      $display("FAIL async_reset state=%0d A=%h B=%h ctl=%h fin=%b res=%h v=%b want all 0",
               state, ALUA, ALUB, ALUControl, ALUFlagIn, result_q, valid);
    end
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_vec++;
    if (state !== 3'd0 || ALUA !== 4'h0) begin
      n_err++;
      $display("FAIL held_thru_reset state=%0d A=%h want 0/0", state, ALUA);
    end
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
    data_in = 4'hE;
    press();
    n_vec++;
    if (state !== 3'd1 || ALUA !== 4'hE) begin
      n_err++;
      $display("FAIL after_reset state=%0d A=%h want 1/E", state, ALUA);
    end
  endtask

  initial begin
    test_reset();
    test_load_seq();
    test_return();
    test_held();
    test_illegal();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
